flappy_game_ctrl: RTL and testbench



---
 rtl/flappy_game_ctrl_if.sv | 27 ++
 rtl/flappy_game_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_flappy_game_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/flappy_game_ctrl_if.sv
//----------------------------------------------------------------------
// flappy_game_ctrl_if : frame pulse, player button and sprite position bus
// Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

interface flappy_game_ctrl_if;
  logic       vneg;
  logic       flap;
  logic [9:0] upx1, upx2, dnx1, dnx2;
  logic [9:0] upy1, upy2, dny1, dny2;
  logic [9:0] birdy;
  logic [7:0] score;
  logic       game_over;

  modport master (
    input  vneg, flap,
    output upx1, upx2, dnx1, dnx2, upy1, upy2, dny1, dny2, birdy, score, game_over
  );

  modport slave (
    output vneg, flap,
    input  upx1, upx2, dnx1, dnx2, upy1, upy2, dny1, dny2, birdy, score, game_over
  );
endinterface

`default_nettype wire

// File: rtl/flappy_game_ctrl.sv
//----------------------------------------------------------------------
// flappy_game_ctrl : per-frame bird physics, pipe scroll and collision
// Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

module flappy_game_ctrl #(
  parameter int BIRD_X       = 445,
  parameter int PLAY_X0      = 320,
  parameter int PIPE_RESET_X = 552,
  parameter int TOP_Y        = 85,
  parameter int GROUND_Y     = 415,
  parameter int GAP          = 64,
  parameter int FLAP_V       = 6,
  parameter int MAX_FALL     = 7,
  parameter int BIRD_Y0      = 240
) (
  input  logic               clk,
  input  logic               rst,
  flappy_game_ctrl_if.master bus
);

  localparam int GAP_BASE = 235;
  localparam int GAP_INIT = 250;
  localparam int X2_INIT  = 392;
  localparam int PIPE_W   = 52;
  localparam int PIPE_H   = 150;
  localparam int BIRD_W   = 34;
  localparam int BIRD_H   = 24;

  localparam logic [9:0]        PASS_X  = 10'(BIRD_X - PIPE_W);
  localparam logic signed [6:0] VN_FLAP = 7'(-FLAP_V);
  localparam logic signed [6:0] VN_MAX  = 7'(MAX_FALL);
  localparam logic signed [10:0] TOP_Y_S = 11'(TOP_Y);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_UPD_BIRD, S_UPD_PIPE, S_CHECK, S_DEAD
  } state_t;

  state_t state, state_n;

  logic [7:0]        lfsr;
  logic [2:0]        sync;
  logic              flap_req, flap_edge, consume;
  logic [9:0]        birdy, birdy_n;
  logic signed [5:0] vel, vel_n;
  logic [9:0]        x1, x1_n, x2, x2_n;
  logic [9:0]        gap1, gap1_n, gap2, gap2_n;
  logic [7:0]        score, score_n;
  logic              game_over, game_over_n;

  logic signed [6:0]  vel_inc, vn;
  logic signed [10:0] vn_ext, y_s;
  logic               wrap1, wrap2, pass1, pass2, hit;
  logic [9:0]         x1_step, x2_step, gap1_step, gap2_step;
  logic [8:0]         score_sum;
  logic [7:0]         score_sat;

  // sync[1:0] is the metastability chain, sync[2] the previous sample
  assign flap_edge = sync[1] & ~sync[2];

  assign vel_inc = {vel[5], vel} + 7'd1;
  assign vn      = flap_req ? VN_FLAP : ((vel_inc > VN_MAX) ? VN_MAX : vel_inc);
  assign vn_ext  = {{4{vn[6]}}, vn};
  assign y_s     = $signed({1'b0, birdy}) + vn_ext;

  assign wrap1     = (x1 == 10'(PLAY_X0));
  assign wrap2     = (x2 == 10'(PLAY_X0));
  assign x1_step   = wrap1 ? 10'(PIPE_RESET_X) : x1 - 10'd1;
  assign x2_step   = wrap2 ? 10'(PIPE_RESET_X) : x2 - 10'd1;
  assign gap1_step = wrap1 ? 10'(GAP_BASE) + {5'd0, lfsr[4:0]} : gap1;
  assign gap2_step = wrap2 ? 10'(GAP_BASE) + {5'd0, lfsr[7:3]} : gap2;
  assign pass1     = (x1_step == PASS_X);
  assign pass2     = (x2_step == PASS_X);
  assign score_sum = {1'b0, score} + {8'd0, pass1} + {8'd0, pass2};
  assign score_sat = score_sum[8] ? 8'hFF : score_sum[7:0];

  function automatic logic pipe_hit(input logic [9:0] x, input logic [9:0] gap,
                                    input logic [9:0] y);
    logic [10:0] xe, ge, ye;
    xe = {1'b0, x};
    ge = {1'b0, gap};
    ye = {1'b0, y};
    pipe_hit = (xe <= 11'(BIRD_X + BIRD_W - 1)) &&
               (xe + 11'(PIPE_W - 1) >= 11'(BIRD_X)) &&
               ((ye < ge) || (ye + 11'(BIRD_H - 1) >= ge + 11'(GAP)));
  endfunction

  assign hit = ({1'b0, birdy} + 11'(BIRD_H - 1) >= 11'(GROUND_Y)) ||
               pipe_hit(x1, gap1, birdy) || pipe_hit(x2, gap2, birdy);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n     = state;
    consume     = 1'b0;
    birdy_n     = birdy;
    vel_n       = vel;
    x1_n        = x1;
    x2_n        = x2;
    gap1_n      = gap1;
    gap2_n      = gap2;
    score_n     = score;
    game_over_n = game_over;
    case (state)
      S_IDLE: begin
        if (bus.vneg && flap_req) begin
          consume = 1'b1;
          vel_n   = VN_FLAP[5:0];
          state_n = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.vneg) state_n = S_UPD_BIRD;
      end
      S_UPD_BIRD: begin
        consume = flap_req;
        if (y_s < TOP_Y_S) begin
          birdy_n = 10'(TOP_Y);
          vel_n   = '0;
        end else begin
          birdy_n = y_s[9:0];
          vel_n   = vn[5:0];
        end
        state_n = S_UPD_PIPE;
      end
      S_UPD_PIPE: begin
        x1_n    = x1_step;
        x2_n    = x2_step;
        gap1_n  = gap1_step;
        gap2_n  = gap2_step;
        score_n = score_sat;
        state_n = S_CHECK;
      end
      S_CHECK: begin
        if (hit) begin
          game_over_n = 1'b1;
          state_n     = S_DEAD;
        end else begin
          state_n = S_RUN;
        end
      end
      S_DEAD: begin
        // restart reloads the game but the LFSR keeps running
        if (bus.vneg && flap_req) begin
          consume     = 1'b1;
          birdy_n     = 10'(BIRD_Y0);
          vel_n       = '0;
          x1_n        = 10'(PIPE_RESET_X);
          x2_n        = 10'(X2_INIT);
          gap1_n      = 10'(GAP_INIT);
          gap2_n      = 10'(GAP_INIT);
          score_n     = '0;
          game_over_n = 1'b0;
          state_n     = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr      <= 8'hA5;
      sync      <= '0;
      flap_req  <= 1'b0;
      birdy     <= 10'(BIRD_Y0);
      vel       <= '0;
      x1        <= 10'(PIPE_RESET_X);
      x2        <= 10'(X2_INIT);
      gap1      <= 10'(GAP_INIT);
      gap2      <= 10'(GAP_INIT);
      score     <= '0;
      game_over <= 1'b0;
    end else begin
      lfsr      <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      sync      <= {sync[1:0], bus.flap};
      flap_req  <= flap_edge | (flap_req & ~consume);
      birdy     <= birdy_n;
      vel       <= vel_n;
      x1        <= x1_n;
      x2        <= x2_n;
      gap1      <= gap1_n;
      gap2      <= gap2_n;
      score     <= score_n;
      game_over <= game_over_n;
    end
  end

  assign bus.upx1      = x1;
  assign bus.dnx1      = x1;
  assign bus.upx2      = x2;
  assign bus.dnx2      = x2;
  assign bus.upy1      = gap1 - 10'(PIPE_H);
  assign bus.upy2      = gap2 - 10'(PIPE_H);
  assign bus.dny1      = gap1 + 10'(GAP);
  assign bus.dny2      = gap2 + 10'(GAP);
  assign bus.birdy     = birdy;
  assign bus.score     = score;
  assign bus.game_over = game_over;

endmodule

`default_nettype wire

// File: tb/tb_flappy_game_ctrl.sv
//----------------------------------------------------------------------
// tb_flappy_game_ctrl : table vectors, corner sequences and a random game
// Rev 1.0
//----------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_flappy_game_ctrl;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DEAD = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  flappy_game_ctrl_if bus();
  flappy_game_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  // free-running LFSR reference: x^8+x^6+x^5+x^4+1, one step per clock
  logic [7:0] tb_lfsr;
  always @(posedge clk or negedge rst) begin
    if (!rst) tb_lfsr <= 8'hA5;
    else      tb_lfsr <= {tb_lfsr[6:0], tb_lfsr[7] ^ tb_lfsr[5] ^ tb_lfsr[4] ^ tb_lfsr[3]};
  end

  int n_cmp = 0;
  int n_err = 0;

  int m_mode, m_birdy, m_vel, m_score;
  int m_x[2];
  int m_g[2];
  bit m_go, m_req;

  typedef struct {
    bit press;
    int birdy;
    int x1;
    int x2;
    int score;
    bit go;
  } vec_t;

  vec_t tbl[36];
  int   rise[14] = '{240, 235, 231, 228, 226, 225, 225, 226, 228, 231, 235, 240, 246, 253};

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_birdy = 240; m_vel = 0; m_score = 0;
    m_x[0] = 552; m_x[1] = 392; m_g[0] = 250; m_g[1] = 250;
    m_go = 1'b0; m_req = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] lf);
    int vn, y;
    case (m_mode)
      M_IDLE: if (m_req) begin m_req = 1'b0; m_vel = -6; m_mode = M_RUN; end
      M_RUN: begin
        if (m_req) begin m_req = 1'b0; vn = -6; end
        else vn = (m_vel + 1 > 7) ? 7 : m_vel + 1;
        y = m_birdy + vn;
        if (y < 85) begin m_birdy = 85; m_vel = 0; end
        else begin m_birdy = y; m_vel = vn; end
        for (int i = 0; i < 2; i++) begin
          if (m_x[i] == 320) begin
            m_x[i] = 552;
            m_g[i] = 235 + ((i == 0) ? int'(lf[4:0]) : int'(lf[7:3]));
          end else m_x[i] = m_x[i] - 1;
          if (m_x[i] == 393 && m_score < 255) m_score++;
        end
        m_go = (m_birdy + 23 >= 415);
        for (int i = 0; i < 2; i++)
          if (m_x[i] <= 478 && m_x[i] + 51 >= 445 &&
              (m_birdy < m_g[i] || m_birdy + 23 >= m_g[i] + 64)) m_go = 1'b1;
        if (m_go) m_mode = M_DEAD;
      end
      default: if (m_req) model_reset();
    endcase
  endtask

  task automatic check_all(input string tag);
    check({tag, "_upx1"}, bus.upx1, m_x[0]);
    check({tag, "_dnx1"}, bus.dnx1, m_x[0]);
    check({tag, "_upx2"}, bus.upx2, m_x[1]);
    check({tag, "_dnx2"}, bus.dnx2, m_x[1]);
    check({tag, "_upy1"}, bus.upy1, m_g[0] - 150);
    check({tag, "_dny1"}, bus.dny1, m_g[0] + 64);
    check({tag, "_upy2"}, bus.upy2, m_g[1] - 150);
    check({tag, "_dny2"}, bus.dny2, m_g[1] + 64);
    check({tag, "_birdy"}, bus.birdy, m_birdy);
    check({tag, "_score"}, bus.score, m_score);
    check({tag, "_over"}, bus.game_over, m_go);
  endtask

  task automatic press_flap();
    @(posedge clk); #1 bus.flap = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.flap = 1'b0;
    repeat (4) @(posedge clk);
    m_req = 1'b1;
  endtask

  // spurious keeps vneg high through the UPD_BIRD and UPD_PIPE cycles
  task automatic run_frame(input bit press, input bit spurious);
    logic [7:0] lf;
    if (press) press_flap();
    @(posedge clk); #1 bus.vneg = 1'b1;
    @(posedge clk); #1 if (!spurious) bus.vneg = 1'b0;
    @(posedge clk); #1 lf = tb_lfsr;
    model_frame(lf);
    check("frame_birdy_e2", bus.birdy, m_birdy);
    @(posedge clk); #1 bus.vneg = 1'b0;
    @(posedge clk); #1;
    check_all("frame");
    repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] lf;
    for (int k = 0; k < 34; k++) begin
      tbl[k].press = (k == 0);
      tbl[k].birdy = (k < 14) ? rise[k] : 253 + 7 * (k - 13);
      tbl[k].x1    = 552 - k;
      tbl[k].x2    = 392 - k;
      tbl[k].score = 0;
      tbl[k].go    = (k == 33);
    end
    tbl[34] = tbl[33];
    tbl[35] = '{1'b1, 240, 552, 392, 0, 1'b0};

    rst = 1'b0; bus.vneg = 1'b0; bus.flap = 1'b0;
    model_reset();
    #22;
    check_all("reset");
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(posedge clk);

    // flap-start, climb, free fall to the ground, frozen DEAD, restart
    for (int k = 0; k < 36; k++) begin
      run_frame(tbl[k].press, 1'b0);
      check($sformatf("tbl%0d_birdy", k), bus.birdy, tbl[k].birdy);
      check($sformatf("tbl%0d_x1", k), bus.upx1, tbl[k].x1);
      check($sformatf("tbl%0d_x2", k), bus.upx2, tbl[k].x2);
      check($sformatf("tbl%0d_score", k), bus.score, tbl[k].score);
      check($sformatf("tbl%0d_over", k), bus.game_over, tbl[k].go);
    end

    // press edge lands on the UPD_BIRD cycle while a request is pending
    run_frame(1'b1, 1'b0);
    press_flap();
    @(posedge clk); #1 bus.flap = 1'b1;
    @(posedge clk); #1 bus.vneg = 1'b1;
    @(posedge clk); #1 bus.vneg = 1'b0;
    @(posedge clk); #1 lf = tb_lfsr;
    model_frame(lf);
    m_req = 1'b1;
    check("setwins_birdy1", bus.birdy, 234);
    @(posedge clk);
    @(posedge clk); #1;
    check_all("setwins");
    bus.flap = 1'b0;
    repeat (4) @(posedge clk);
    run_frame(1'b0, 1'b0);
    check("setwins_birdy2", bus.birdy, 228);
    run_frame(1'b0, 1'b0);
    check("setwins_birdy3", bus.birdy, 223);

    // flap every frame until the bird sits on the top row
    for (int k = 0; k < 25; k++) run_frame(1'b1, 1'b0);
    check("clamp_birdy", bus.birdy, 85);
    check("clamp_over", bus.game_over, 0);
    run_frame(1'b0, 1'b0);
    check("clamp_vel0_birdy", bus.birdy, 86);
    run_frame(1'b0, 1'b0);
    check("clamp_fall_birdy", bus.birdy, 88);

    // asynchronous reset while the pipes are being updated
    @(posedge clk); #1 bus.vneg = 1'b1;
    @(posedge clk); #1 bus.vneg = 1'b0;
    @(posedge clk); #1 check("pre_rst_birdy", bus.birdy, 91);
    rst = 1'b0;
    #1;
    check("rst_birdy", bus.birdy, 240);
    check("rst_x1", bus.upx1, 552);
    check("rst_x2", bus.upx2, 392);
    check("rst_upy1", bus.upy1, 100);
    check("rst_dny2", bus.dny2, 314);
    check("rst_score", bus.score, 0);
    check("rst_over", bus.game_over, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    model_reset();

    // autopilot through the gaps, random timing and spurious vneg
    for (int f = 0; f < 420; f++) begin
      int g, t, best;
      bit p;
      g = 250; best = 1000;
      for (int i = 0; i < 2; i++)
        if (m_x[i] >= 394 && m_x[i] < best) begin best = m_x[i]; g = m_g[i]; end
      t = g + 21 + int'($urandom_range(0, 12));
      if (m_mode != M_RUN) p = 1'b1;
      else p = (m_vel >= 0) && (m_birdy > t);
      run_frame(p, (m_mode == M_RUN) && ($urandom_range(0, 3) == 0));
    end

    // unguided random play
    for (int f = 0; f < 150; f++)
      run_frame($urandom_range(0, 2) == 0, (m_mode == M_RUN) && ($urandom_range(0, 3) == 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
